operand_fwd_ctrl: RTL
=====================

# operand_fwd_ctrl

Forwarding and hazard controller that generates the 2-bit select for the ALU operand quad 4:1 multiplexers in the EX stage. It tracks the destination registers of in-flight instructions in EX, MEM and WB with a small shadow pipeline. It compares them against the source registers of the instruction in ID and registers the resulting selects so they are valid when that instruction reaches EX. It also detects load-use hazards and requests a one-cycle stall.

## Interface
- REG_BITS, 3, width of a register specifier (8 GPRs)
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- hold  in  1  global freeze (memory stall); all state and outputs hold
- flush  in  1  branch/jump flush; ID instruction is discarded
- id_valid  in  1  ID holds a real instruction
- id_wr_en  in  1  ID instruction writes a GPR
- id_wr_reg  in  REG_BITS  ID destination register
- id_is_load  in  1  ID instruction is a load
- id_rd_a_en, id_rd_b_en  in  1 each  ID instruction reads operand A / B from a GPR
- id_src_a, id_src_b  in  REG_BITS each  ID source registers
- id_use_imm_b  in  1  operand B is the immediate
- sel_a, sel_b  out  2 each  registered operand mux selects: 00 register file, 01 EX/MEM result, 10 MEM/WB result, 11 immediate (sel_b only)
- load_stall  out  1  combinational: hold PC/IF/ID this cycle, insert a bubble into EX

## Operation
- Shadow pipeline: three slots, EX, MEM and WB. Each slot holds {valid, wr_en, wr_reg, is_load}.
- "Live" slot: valid && wr_en.
- Advance, when hold=0, on every clock edge:
  - WB<=MEM, MEM<=EX.
  - EX<=ID fields, with valid = id_valid && !flush && !load_stall.
- Load-use hazard: load_stall = id_valid && !flush && EX live && EX.is_load && (match A || match B).
  - match A = id_rd_a_en && id_src_a==EX.wr_reg.
  - match B = id_rd_b_en && !id_use_imm_b && id_src_b==EX.wr_reg.
- Select generation per operand, evaluated in ID, registered at the edge. Priority top-down:
  - Operand B only: id_use_imm_b=1 -> 11.
  - Read not enabled -> 00.
  - EX slot live and register matches -> 01 (result will be in EX/MEM).
  - MEM slot live and register matches -> 10 (result will be in MEM/WB).
  - Otherwise -> 00. The register file is write-through, so the WB slot needs no forwarding.
- When load_stall=1 or flush=1 or id_valid=0, sel_a/sel_b load 00 (bubble).
- flush overrides load_stall: load_stall is 0 whenever flush=1.
- Register 0 is a normal GPR; it is never special-cased.

## Timing
- Reset (async, rst_n=0): all slot valid bits 0, sel_a=00, sel_b=00, load_stall=0. Outputs leave reset on the first edge after rst_n rises.
- sel_a/sel_b latency: 1 cycle. Values computed from ID inputs in cycle N appear in cycle N+1, aligned with that instruction in EX.
- load_stall is combinational, same cycle as the ID inputs. The load moves to MEM on the next edge. The stalled instruction re-evaluates in the next cycle and gets select 10 for the matching operand.
- hold=1 freezes slots and sel outputs. load_stall still reflects current state and inputs; it is ignored by the pipeline while hold=1.
- Simultaneous hold and flush: hold wins. flush must be reasserted after hold drops.
- rst_n asserted mid-stall clears load_stall immediately because the EX slot is invalidated.

## Test plan
- Back-to-back dependency: ADD r3 then SUB r4,r3,r1 (src_a=3) -> cycle after SUB in ID, sel_a=01, sel_b=00, load_stall=0.
- Distance 2: ADD r5, NOP, AND r6,r2,r5 (src_b=5) -> sel_b=10. With ADD r5 both one and two ahead writing r5, the nearer one wins -> sel_b=01.
- Load-use: LD r2 then ADD r7,r2,r2 -> load_stall=1 for exactly one cycle, sel regs load 00 (bubble). Next cycle load_stall=0 and sel_a=sel_b=10.
- Immediate and disabled reads: ADDI with src_b matching EX r3 and id_use_imm_b=1 -> sel_b=11, no stall even after a load to r3. id_rd_a_en=0 with a matching src_a -> sel_a=00.
- Flush and hold: flush=1 with a load-use match -> load_stall=0, EX slot invalid, sel=00. hold=1 for 3 cycles -> sel and slots unchanged, then resume correctly.
- Async reset mid-stream: drop rst_n between clock edges while sel_a=01 and load_stall=1 -> sel_a=00 and load_stall=0 immediately. No forwarding from pre-reset instructions after release.

Source files
------------

// File: rtl/operand_fwd_ctrl.sv
// -----------------------------------------------------------------------------
// operand_fwd_ctrl
//
// Forwarding and load-use hazard controller for the EX-stage ALU operand
// muxes. A small shadow pipeline tracks the destination register of the
// instructions one stage (EX) and two stages (MEM) ahead of the instruction
// in ID. The ID source registers are compared against them, and the resulting
// mux selects are registered so they line up with that instruction once it
// reaches EX.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   hold              global freeze: shadow slots and selects keep their value
//   flush             discard the instruction in ID
//   id_valid          ID holds a real instruction
//   id_wr_en          ID instruction writes a GPR
//   id_wr_reg         ID destination register
//   id_is_load        ID instruction is a load
//   id_rd_a_en/_b_en  ID instruction reads operand A / B from a GPR
//   id_src_a/_b       ID source registers
//   id_use_imm_b      operand B is the immediate
//   sel_a, sel_b      registered selects: 00 regfile, 01 EX/MEM, 10 MEM/WB,
//                     11 immediate (sel_b only)
//   load_stall        combinational: freeze PC/IF/ID, bubble into EX
// -----------------------------------------------------------------------------
module operand_fwd_ctrl #(
  parameter int REG_BITS = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                hold,
  input  logic                flush,
  input  logic                id_valid,
  input  logic                id_wr_en,
  input  logic [REG_BITS-1:0] id_wr_reg,
  input  logic                id_is_load,
  input  logic                id_rd_a_en,
  input  logic                id_rd_b_en,
  input  logic [REG_BITS-1:0] id_src_a,
  input  logic [REG_BITS-1:0] id_src_b,
  input  logic                id_use_imm_b,
  output logic [1:0]          sel_a,
  output logic [1:0]          sel_b,
  output logic                load_stall
);

  localparam logic [1:0] SEL_RF    = 2'b00;
  localparam logic [1:0] SEL_EXMEM = 2'b01;
  localparam logic [1:0] SEL_MEMWB = 2'b10;
  localparam logic [1:0] SEL_IMM   = 2'b11;

  // Shadow slot for the instruction in EX.
  logic                ex_valid_q,   ex_valid_d;
  logic                ex_wr_en_q,   ex_wr_en_d;
  logic [REG_BITS-1:0] ex_wr_reg_q,  ex_wr_reg_d;
  logic                ex_is_load_q, ex_is_load_d;

  // Shadow slot for the instruction in MEM. Its load flag is never consulted
  // (a load in MEM already has its data for MEM/WB forwarding), so it is not
  // kept. No WB slot is kept either: the register file is write-through, so
  // an instruction in WB is already visible to a register-file read in ID.
  logic                mem_valid_q,  mem_valid_d;
  logic                mem_wr_en_q,  mem_wr_en_d;
  logic [REG_BITS-1:0] mem_wr_reg_q, mem_wr_reg_d;

  logic [1:0]          sel_a_q, sel_a_d;
  logic [1:0]          sel_b_q, sel_b_d;

  logic ex_live;
  logic mem_live;
  logic id_live;
  logic match_a;
  logic match_b;
  logic stall;

  // Forwarding priority for one GPR-read operand: the nearer producer (EX)
  // wins over the farther one (MEM); no match reads the register file.
  function automatic logic [1:0] fwd_sel(
    input logic                rd_en,
    input logic [REG_BITS-1:0] src,
    input logic                ex_lv,
    input logic [REG_BITS-1:0] ex_reg,
    input logic                mem_lv,
    input logic [REG_BITS-1:0] mem_reg
  );
    logic [1:0] s;
    s = SEL_RF;
    if (rd_en) begin
      if (ex_lv && (src == ex_reg)) begin
        s = SEL_EXMEM;
      end else if (mem_lv && (src == mem_reg)) begin
        s = SEL_MEMWB;
      end
    end
    return s;
  endfunction

  always_comb begin
    ex_live  = ex_valid_q && ex_wr_en_q;
    mem_live = mem_valid_q && mem_wr_en_q;
    id_live  = id_valid && !flush;

    match_a  = id_rd_a_en && (id_src_a == ex_wr_reg_q);
    match_b  = id_rd_b_en && !id_use_imm_b && (id_src_b == ex_wr_reg_q);

    // A load in EX has no data until the end of MEM, so a consumer directly
    // behind it must wait one cycle. Gated by id_live so flush always wins.
    stall    = id_live && ex_live && ex_is_load_q && (match_a || match_b);
  end

  assign load_stall = stall;

  always_comb begin
    ex_valid_d   = ex_valid_q;
    ex_wr_en_d   = ex_wr_en_q;
    ex_wr_reg_d  = ex_wr_reg_q;
    ex_is_load_d = ex_is_load_q;
    mem_valid_d  = mem_valid_q;
    mem_wr_en_d  = mem_wr_en_q;
    mem_wr_reg_d = mem_wr_reg_q;
    sel_a_d      = sel_a_q;
    sel_b_d      = sel_b_q;

    // hold freezes everything, including a pending flush or stall request.
    if (!hold) begin
      mem_valid_d  = ex_valid_q;
      mem_wr_en_d  = ex_wr_en_q;
      mem_wr_reg_d = ex_wr_reg_q;

      // A stalled instruction stays in ID; EX receives a bubble.
      ex_valid_d   = id_live && !stall;
      ex_wr_en_d   = id_wr_en;
      ex_wr_reg_d  = id_wr_reg;
      ex_is_load_d = id_is_load;

      if (!id_live || stall) begin
        sel_a_d = SEL_RF;
        sel_b_d = SEL_RF;
      end else begin
        sel_a_d = fwd_sel(id_rd_a_en, id_src_a, ex_live, ex_wr_reg_q,
                          mem_live, mem_wr_reg_q);
        if (id_use_imm_b) begin
          sel_b_d = SEL_IMM;
        end else begin
          sel_b_d = fwd_sel(id_rd_b_en, id_src_b, ex_live, ex_wr_reg_q,
                            mem_live, mem_wr_reg_q);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q   <= 1'b0;
      ex_wr_en_q   <= 1'b0;
      ex_wr_reg_q  <= '0;
      ex_is_load_q <= 1'b0;
      mem_valid_q  <= 1'b0;
      mem_wr_en_q  <= 1'b0;
      mem_wr_reg_q <= '0;
      sel_a_q      <= SEL_RF;
      sel_b_q      <= SEL_RF;
    end else begin
      ex_valid_q   <= ex_valid_d;
      ex_wr_en_q   <= ex_wr_en_d;
      ex_wr_reg_q  <= ex_wr_reg_d;
      ex_is_load_q <= ex_is_load_d;
      mem_valid_q  <= mem_valid_d;
      mem_wr_en_q  <= mem_wr_en_d;
      mem_wr_reg_q <= mem_wr_reg_d;
      sel_a_q      <= sel_a_d;
      sel_b_q      <= sel_b_d;
    end
  end

  assign sel_a = sel_a_q;
  assign sel_b = sel_b_q;

endmodule
